user_position_ctl: RTL and testbench

USER_POSITION_CTL -- requirements
Module: user_position_ctl

---
 rtl/user_position_ctl.sv | 229 ++++++++++++++++++++++
 tb/tb_user_position_ctl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_position_ctl.sv
// user_position_ctl: moves a sprite by STEP pixels per frame in response to
// key levels, clamps it to the visible screen and refuses any move that would
// overlap an entry of the external obstacle table. Obstacle entries are read
// one per cycle from a table with one cycle of read latency. Each new position
// is checked against every entry before it is committed.
module user_position_ctl #(
  parameter int STEP     = 4,
  parameter int SPRITE_W = 100,
  parameter int SPRITE_H = 100,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 250,
  parameter int N_OBST   = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        freeze,
  output logic [2:0]  obst_addr,
  input  logic [47:0] obst_data,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // cnt counts cycles spent in CHECK; it must reach N_OBST (last compare).
  localparam int CW = $clog2(N_OBST + 1);

  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic signed [12:0] MAX_X  = 13'(SCREEN_W - SPRITE_W);
  localparam logic signed [12:0] MAX_Y  = 13'(SCREEN_H - SPRITE_H);
  localparam logic [12:0]        SPR_W  = 13'(SPRITE_W);
  localparam logic [12:0]        SPR_H  = 13'(SPRITE_H);
  localparam logic [CW-1:0]      LAST_CNT  = CW'(N_OBST);
  localparam logic [CW-1:0]      LAST_ADDR = CW'(N_OBST - 1);

  state_t        state;
  state_t        state_next;
  logic          vs_prev;
  logic          tick;
  logic [11:0]   cand_x;
  logic [11:0]   cand_y;
  logic [11:0]   calc_x;
  logic [11:0]   calc_y;
  logic          cand_same;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] addr_sel;
  logic [2:0]    addr_next;
  logic          busy_next;
  logic          cmp_en;
  logic          cmp_last;
  logic          hit;

  // Signed move term for one axis; opposing keys cancel.
  function automatic logic signed [12:0] axis_step(input logic pos_key,
                                                   input logic neg_key);
    logic signed [12:0] d;
    if (pos_key && !neg_key) begin
      d = STEP_S;
    end else if (neg_key && !pos_key) begin
      d = -STEP_S;
    end else begin
      d = 13'sd0;
    end
    return d;
  endfunction

  // Apply a move and clamp the result into [0, max].
  function automatic logic [11:0] move_clamp(input logic [11:0]        pos,
                                             input logic signed [12:0] d,
                                             input logic signed [12:0] max);
    logic signed [12:0] v;
    logic [11:0]        r;
    v = $signed({1'b0, pos}) + d;
    if (v < 13'sd0) begin
      r = 12'd0;
    end else if (v > max) begin
      r = max[11:0];
    end else begin
      r = v[11:0];
    end
    return r;
  endfunction

  // Rectangle overlap of the sprite at (cx,cy) with one table entry; an entry
  // with x0 == x1 is an unused slot.
  function automatic logic collides(input logic [11:0] cx,
                                    input logic [11:0] cy,
                                    input logic [47:0] e);
    logic [12:0] x0;
    logic [12:0] y0;
    logic [12:0] x1;
    logic [12:0] y1;
    logic [12:0] cx13;
    logic [12:0] cy13;
    x0   = {1'b0, e[47:36]};
    y0   = {1'b0, e[35:24]};
    x1   = {1'b0, e[23:12]};
    y1   = {1'b0, e[11:0]};
    cx13 = {1'b0, cx};
    cy13 = {1'b0, cy};
    return (x0 != x1) && (cx13 < x1) && ((cx13 + SPR_W) > x0) &&
           (cy13 < y1) && ((cy13 + SPR_H) > y0);
  endfunction

  assign tick      = vsync_in & ~vs_prev;
  assign calc_x    = move_clamp(x_pos, axis_step(key_right, key_left), MAX_X);
  assign calc_y    = move_clamp(y_pos, axis_step(key_down, key_up), MAX_Y);
  assign cand_same = (calc_x == x_pos) && (calc_y == y_pos);
  // obst_data for entry cnt-1 is valid once cnt has advanced past zero.
  assign cmp_en    = (cnt != {CW{1'b0}});
  assign cmp_last  = (cnt == LAST_CNT);
  assign hit       = cmp_en && collides(cand_x, cand_y, obst_data);

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision; freeze aborts any operation in progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick && !freeze) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (freeze || cand_same) begin
          state_next = IDLE;
        end else begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (freeze || hit) begin
          state_next = IDLE;
        end else if (cmp_en && cmp_last) begin
          state_next = COMMIT;
        end else begin
          state_next = CHECK;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the CHECK cycle counter.
  always_comb begin
    cnt_next  = {CW{1'b0}};
    addr_sel  = {CW{1'b0}};
    busy_next = (state_next != IDLE);
    if (state_next == CHECK) begin
      if (state == CHECK) begin
        cnt_next = cnt + CW'(1);
      end else begin
        cnt_next = {CW{1'b0}};
      end
      if (cnt_next > LAST_ADDR) begin
        addr_sel = LAST_ADDR;
      end else begin
        addr_sel = cnt_next;
      end
    end else begin
      cnt_next = {CW{1'b0}};
      addr_sel = {CW{1'b0}};
    end
    addr_next = 3'(addr_sel);
  end

  // Datapath and output registers; position is only written in COMMIT.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_prev   <= 1'b1;
      x_pos     <= 12'(X_INIT);
      y_pos     <= 12'(Y_INIT);
      cand_x    <= 12'd0;
      cand_y    <= 12'd0;
      cnt       <= {CW{1'b0}};
      obst_addr <= 3'd0;
      busy      <= 1'b0;
    end else begin
      vs_prev   <= vsync_in;
      cnt       <= cnt_next;
      obst_addr <= addr_next;
      busy      <= busy_next;
      if (state == CALC) begin
        cand_x <= calc_x;
        cand_y <= calc_y;
      end else begin
        cand_x <= cand_x;
        cand_y <= cand_y;
      end
      if (state == COMMIT && !freeze) begin
        x_pos <= cand_x;
        y_pos <= cand_y;
      end else begin
        x_pos <= x_pos;
        y_pos <= y_pos;
      end
    end
  end

endmodule

// File: tb/tb_user_position_ctl.sv
// Bench for user_position_ctl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a frame-level model.
module tb_user_position_ctl;

  localparam int STEP = 4;
  localparam int SW   = 100;
  localparam int SH   = 100;
  localparam int SCW  = 800;
  localparam int SCH  = 600;
  localparam int N    = 8;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_in = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        freeze = 1'b0;
  logic [2:0]  obst_addr;
  logic [47:0] obst_data = 48'd0;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        busy;

  logic [47:0] tbl [N];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // frame-level model state
  int x_m = 0;
  int y_m = 250;
  int cx_m = 0;
  int cy_m = 0;
  int m_e = 0;
  int m_end = 0;
  bit m_busy = 1'b0;
  bit m_commit = 1'b0;
  bit vsp_m = 1'b1;

  user_position_ctl #(
    .STEP(STEP), .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(SCW), .SCREEN_H(SCH),
    .X_INIT(0), .Y_INIT(250), .N_OBST(N)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .freeze(freeze), .obst_addr(obst_addr), .obst_data(obst_data),
    .x_pos(x_pos), .y_pos(y_pos), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // obstacle table with one cycle of read latency
  always @(posedge pclk) obst_data <= tbl[obst_addr];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic bit overlaps(input int cx, input int cy, input logic [47:0] e);
    int x0, y0, x1, y1;
    x0 = int'(e[47:36]); y0 = int'(e[35:24]);
    x1 = int'(e[23:12]); y1 = int'(e[11:0]);
    return (x0 != x1) && (cx < x1) && (cx + SW > x0) && (cy < y1) && (cy + SH > y0);
  endfunction

  // Model: a frame is accepted on a vsync rise while idle; one edge later the
  // keys decide the target; the frame then ends 1 edge later (no move),
  // k+3 edges after acceptance (first hit at entry k) or N+3 (commit).
  always @(posedge pclk) begin
    bit tk;
    int k;
    tk = vsync_in && !vsp_m;
    vsp_m = vsync_in;
    if (rst) begin
      vsp_m = 1'b1; m_busy = 1'b0; m_e = 0; m_commit = 1'b0;
      x_m = 0; y_m = 250;
    end else if (!m_busy) begin
      if (tk && !freeze) begin
        m_busy = 1'b1; m_e = 0; m_commit = 1'b0;
      end
    end else if (freeze) begin
      m_busy = 1'b0;
    end else begin
      m_e++;
      if (m_e == 1) begin
        cx_m = clampi(x_m + (int'(key_right) - int'(key_left)) * STEP, SCW - SW);
        cy_m = clampi(y_m + (int'(key_down) - int'(key_up)) * STEP, SCH - SH);
        if (cx_m == x_m && cy_m == y_m) begin
          m_busy = 1'b0;
        end else begin
          k = -1;
          for (int i = N - 1; i >= 0; i--) if (overlaps(cx_m, cy_m, tbl[i])) k = i;
          m_commit = (k < 0);
          m_end = (k < 0) ? N + 3 : k + 3;
        end
      end else if (m_e == m_end) begin
        m_busy = 1'b0;
        if (m_commit) begin x_m = cx_m; y_m = cy_m; end
      end
    end
  end

  // per-cycle comparison against the model
  always @(posedge pclk) begin
    #1;
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("x_pos", int'(x_pos), x_m);
      chk("y_pos", int'(y_pos), y_m);
      if (!m_busy || m_e == 0 || (m_commit && m_e == N + 2))
        chk("addr_idle", int'(obst_addr), 0);
      else if (m_e <= N)
        chk("addr_seq", int'(obst_addr), m_e - 1);
    end
  end

  // raise vsync, return #1 after the n-th edge following the tick edge
  task automatic pulse_and_wait(input int n);
    @(negedge pclk) vsync_in = 1'b1;
    @(posedge pclk);
    @(negedge pclk) vsync_in = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic run_frame();
    pulse_and_wait(12);
  endtask

  function automatic logic [47:0] rand_entry();
    int x0, y0, x1, y1;
    x0 = $urandom_range(0, 799); x1 = x0 + $urandom_range(0, 120);
    y0 = $urandom_range(0, 599); y1 = y0 + $urandom_range(0, 120);
    return {12'(x0), 12'(y0), 12'(x1), 12'(y1)};
  endfunction

  initial begin
    for (int i = 0; i < N; i++) tbl[i] = 48'd0;

    // reset
    @(negedge pclk) rst = 1'b1;
    @(posedge pclk); #1 chk_en = 1'b1;
    @(negedge pclk);
    @(negedge pclk) rst = 1'b0;
    @(posedge pclk); #1;
    chk("rst_x", int'(x_pos), 0);
    chk("rst_y", int'(y_pos), 250);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(obst_addr), 0);
    chk("model_rst_y", y_m, 250);

    // three moves right, each landing 11 edges after its tick
    key_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_and_wait(10);
      chk("x_before_e11", int'(x_pos), 4 * i);
      @(posedge pclk); #1;
      chk("x_at_e11", int'(x_pos), 4 * (i + 1));
      chk("y_hold", int'(y_pos), 250);
    end
    chk("model_x_pin", x_m, 12);

    // clamp at left edge
    key_right = 1'b0; key_left = 1'b1;
    repeat (3) run_frame();
    chk("x_zero", int'(x_pos), 0);
    pulse_and_wait(1);
    chk("noop_x_busy", int'(busy), 0);
    chk("noop_x_addr", int'(obst_addr), 0);
    repeat (11) @(posedge pclk); #1;
    chk("x_stays_zero", int'(x_pos), 0);

    // clamp at bottom edge
    key_left = 1'b0; key_down = 1'b1;
    repeat (63) run_frame();
    chk("y_bottom", int'(y_pos), 500);
    chk("model_y_pin", y_m, 500);
    pulse_and_wait(1);
    chk("noop_y_busy", int'(busy), 0);
    repeat (11) @(posedge pclk); #1;
    chk("y_stays_500", int'(y_pos), 500);

    // obstacle at entry 5: touching its left edge is allowed, overlap is not
    key_down = 1'b0; key_right = 1'b1;
    tbl[5] = {12'd200, 12'd0, 12'd300, 12'd600};
    repeat (24) run_frame();
    chk("x_96", int'(x_pos), 96);
    run_frame();
    chk("x_touch_100", int'(x_pos), 100);
    pulse_and_wait(7);
    chk("busy_before_hit", int'(busy), 1);
    repeat (2) @(posedge pclk); #1;
    chk("busy_low_e9", int'(busy), 0);
    repeat (2) @(posedge pclk); #1;
    chk("x_blocked", int'(x_pos), 100);

    // opposing vertical keys cancel
    tbl[5] = 48'd0;
    key_up = 1'b1; key_down = 1'b1;
    run_frame();
    chk("diag_x", int'(x_pos), 104);
    chk("diag_y", int'(y_pos), 500);
    key_up = 1'b0; key_down = 1'b0;

    // freeze aborts mid-frame and blocks further ticks
    pulse_and_wait(4);
    @(negedge pclk) freeze = 1'b1;
    @(posedge pclk); #1;
    chk("freeze_abort", int'(busy), 0);
    repeat (8) @(posedge pclk); #1;
    chk("freeze_no_commit", int'(x_pos), 104);
    pulse_and_wait(2);
    chk("freeze_ignores_tick", int'(busy), 0);
    repeat (10) @(posedge pclk); #1;
    chk("freeze_x_hold", int'(x_pos), 104);
    @(negedge pclk) freeze = 1'b0;

    // second vsync rise while busy is ignored
    pulse_and_wait(3);
    @(negedge pclk) vsync_in = 1'b1;
    @(negedge pclk) vsync_in = 1'b0;
    repeat (7) @(posedge pclk); #1;
    chk("x_after_busy_tick", int'(x_pos), 108);
    chk("busy_after_commit", int'(busy), 0);
    repeat (12) @(posedge pclk); #1;
    chk("second_tick_ignored", int'(x_pos), 108);

    // reset mid-CHECK, vsync held high through release
    pulse_and_wait(5);
    @(negedge pclk) begin rst = 1'b1; vsync_in = 1'b1; end
    @(posedge pclk); #1;
    chk("midrst_x", int'(x_pos), 0);
    chk("midrst_y", int'(y_pos), 250);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_addr", int'(obst_addr), 0);
    @(negedge pclk) rst = 1'b0;
    repeat (3) @(posedge pclk); #1;
    chk("no_tick_at_release", int'(busy), 0);
    @(negedge pclk) vsync_in = 1'b0;
    key_right = 1'b0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge pclk);
      if ($urandom_range(0, 7) == 0) {key_up, key_down, key_left, key_right} = 4'($urandom);
      if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
      if (freeze) begin
        if ($urandom_range(0, 5) == 0) freeze = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        freeze = 1'b1;
      end
      rst = ($urandom_range(0, 699) == 0);
      if (!m_busy && $urandom_range(0, 19) == 0) tbl[$urandom_range(0, N - 1)] = rand_entry();
    end
    @(negedge pclk) rst = 1'b0;
    repeat (2) @(posedge pclk); #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
